// File: rtl/weight_loader_if.sv
// Weight loader bus: command handshake, beat stream, and the kernel/enable
// outputs that fan out to the per-OCU weight buffers.
// slave = weight_loader side, master = command/beat source side.
interface weight_loader_if #(
   parameter int N_I    = 512,
   parameter int K      = 3,
   parameter int N_OCU  = 16,
   parameter int WORD_W = 64
);
   localparam int OCU_W = (N_OCU > 1) ? $clog2(N_OCU) : 1;

   logic                              cmd_valid_i;
   logic                              cmd_ready_o;
   logic                              cmd_flush_i;
   logic [OCU_W-1:0]                  cmd_ocu_i;
   logic                              beat_valid_i;
   logic                              beat_ready_o;
   logic [WORD_W-1:0]                 beat_i;
   logic                              beat_par_i;
   logic [0:K-1][0:K-1][0:N_I-1][1:0] data_o;
   logic [N_OCU-1:0]                  save_en_o;
   logic [N_OCU-1:0]                  flush_o;
   logic                              busy_o;
   logic                              done_o;
   logic                              err_o;

   modport slave (
      input  cmd_valid_i, cmd_flush_i, cmd_ocu_i,
      input  beat_valid_i, beat_i, beat_par_i,
      output cmd_ready_o, beat_ready_o, data_o, save_en_o, flush_o,
      output busy_o, done_o, err_o
   );

   modport master (
      output cmd_valid_i, cmd_flush_i, cmd_ocu_i,
      output beat_valid_i, beat_i, beat_par_i,
      input  cmd_ready_o, beat_ready_o, data_o, save_en_o, flush_o,
      input  busy_o, done_o, err_o
   );
endinterface

// File: rtl/weight_loader.sv
// weight_loader: gathers WORD_W-bit beats into one K*K*N_I ternary kernel and
// hands it to one OCU weight buffer with a single-cycle one-hot save enable,
// or issues a single-cycle one-hot flush. The kernel stays stable on data_o
// for the whole enable pulse and the following hold cycle so transparent-low
// latches downstream capture cleanly.
// Optional feature macro: WEIGHT_LOADER_PARITY_EN (per-beat even-parity check,
// sticky err_o, save enable suppressed for a kernel that saw a bad beat).
module weight_loader #(
   parameter int N_I    = 512,
   parameter int K      = 3,
   parameter int N_OCU  = 16,
   parameter int WORD_W = 64
) (
   input  logic           clk_i,
   input  logic           rst_i,
   weight_loader_if.slave wl_if
);
   localparam int TOT   = K * K * N_I * 2;
   localparam int BEATS = TOT / WORD_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OCU_W = (N_OCU > 1) ? $clog2(N_OCU) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_COMMIT,
      S_HOLD,
      S_FLUSH
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [OCU_W-1:0] r_ocu;
   logic [TOT-1:0]   r_data;
   logic [N_OCU-1:0] r_save_en;
   logic [N_OCU-1:0] r_flush;
   logic             r_done;

   logic             w_cmd_fire;
   logic             w_beat_fire;
   logic             w_last_beat;
   logic             w_suppress;
   logic [N_OCU-1:0] w_cmd_onehot;
   logic [N_OCU-1:0] w_save_onehot;
   logic [BEATS-1:0] w_slot;

   assign w_cmd_fire  = wl_if.cmd_valid_i && (r_state == S_IDLE);
   assign w_beat_fire = wl_if.beat_valid_i && (r_state == S_FILL);
   assign w_last_beat = (r_cnt == CNT_W'(BEATS - 1));

   // One-hot decode; an index >= N_OCU matches no bit, so out-of-range
   // targets complete without driving any enable or flush.
   generate
      for (genvar gi = 0; gi < N_OCU; gi++) begin : g_onehot
         assign w_cmd_onehot[gi]  = (wl_if.cmd_ocu_i == OCU_W'(gi));
         assign w_save_onehot[gi] = (r_ocu == OCU_W'(gi));
      end
   endgenerate

`ifdef WEIGHT_LOADER_PARITY_EN
   logic r_err;
   logic r_kerr;
   logic w_par_bad;

   assign w_par_bad  = (^wl_if.beat_i) != wl_if.beat_par_i;
   assign w_suppress = r_kerr || (w_beat_fire && w_par_bad);
   assign wl_if.err_o = r_err;

   // Sticky error flag plus a per-kernel flag that blocks this kernel's save.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_err  <= 1'b0;
         r_kerr <= 1'b0;
      end else begin
         if (w_cmd_fire)
            r_kerr <= 1'b0;
         else if (w_beat_fire && w_par_bad)
            r_kerr <= 1'b1;
         if (w_beat_fire && w_par_bad)
            r_err <= 1'b1;
      end
   end
`else
   assign w_suppress  = 1'b0;
   assign wl_if.err_o = 1'b0;
`endif

   // Each beat owns a fixed WORD_W slice; beat 0 lands at the MSB end,
   // which is element [0][0][0] of the kernel.
   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
         assign w_slot[gi] = w_beat_fire && (r_cnt == CNT_W'(gi));

         // Capture this slot's beat; contents persist until overwritten.
         always_ff @(posedge clk_i) begin
            if (rst_i)
               r_data[TOT-1-gi*WORD_W -: WORD_W] <= '0;
            else if (w_slot[gi])
               r_data[TOT-1-gi*WORD_W -: WORD_W] <= wl_if.beat_i;
         end
      end
   endgenerate

   // Control FSM; enables and done are registered so each is a clean 1-cycle pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_ocu     <= '0;
         r_save_en <= '0;
         r_flush   <= '0;
         r_done    <= 1'b0;
      end else begin
         r_save_en <= '0;
         r_flush   <= '0;
         r_done    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_cmd_fire) begin
                  r_ocu <= wl_if.cmd_ocu_i;
                  r_cnt <= '0;
                  if (wl_if.cmd_flush_i) begin
                     r_state <= S_FLUSH;
                     r_flush <= w_cmd_onehot;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_FILL;
                  end
               end
            end
            S_FILL: begin
               if (w_beat_fire) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last_beat) begin
                     r_state   <= S_COMMIT;
                     r_save_en <= w_suppress ? '0 : w_save_onehot;
                  end
               end
            end
            S_COMMIT: begin
               r_state <= S_HOLD;
               r_done  <= 1'b1;
            end
            S_HOLD: begin
               r_state <= S_IDLE;
            end
            S_FLUSH: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign wl_if.cmd_ready_o  = (r_state == S_IDLE);
   assign wl_if.beat_ready_o = (r_state == S_FILL);
   assign wl_if.busy_o       = (r_state != S_IDLE);
   assign wl_if.done_o       = r_done;
   assign wl_if.save_en_o    = r_save_en;
   assign wl_if.flush_o      = r_flush;
   assign wl_if.data_o       = r_data;

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader (K=1, N_I=32, WORD_W=16, N_OCU=4).
// Stimulus pushes expected enable/done events; a negedge monitor pops and
// compares whenever the DUT shows an enable or a done pulse.
module tb_weight_loader;
   localparam int N_I    = 32;
   localparam int K      = 1;
   localparam int N_OCU  = 4;
   localparam int WORD_W = 16;
   localparam int BEATS  = 4;

   typedef struct {
      bit          is_flush;
      logic [3:0]  oh;
      logic [63:0] data;
   } ev_t;

   typedef struct {
      bit          is_flush;
      bit          chk_data;
      logic [63:0] data;
      int          lat;
      logic        err;
   } dn_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   weight_loader_if #(.N_I(N_I), .K(K), .N_OCU(N_OCU), .WORD_W(WORD_W)) bus ();

   weight_loader #(.N_I(N_I), .K(K), .N_OCU(N_OCU), .WORD_W(WORD_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .wl_if (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int hs_cyc = 0;
   int leak  = 0;
   ev_t ev_q[$];
   dn_t dn_q[$];
   logic [63:0] model_data = '0;
   logic        model_err  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every enable and every done pulse must match a queued expectation.
   always @(negedge clk) begin : mon
      ev_t e;
      dn_t d;
      if (!rst) begin
         if (bus.save_en_o != '0 || bus.flush_o != '0) begin
            if (ev_q.size() == 0) begin
               check("unexpected_enable", {56'd0, bus.save_en_o, bus.flush_o}, 64'd0);
            end else begin
               e = ev_q.pop_front();
               check("save_en", {60'd0, bus.save_en_o}, e.is_flush ? 64'd0 : {60'd0, e.oh});
               check("flush",   {60'd0, bus.flush_o},   e.is_flush ? {60'd0, e.oh} : 64'd0);
               check("enable_data", bus.data_o, e.data);
               $display("enable: flush=%0d oh=%b data=%h", e.is_flush, e.is_flush ? bus.flush_o : bus.save_en_o, bus.data_o);
            end
         end
         if (bus.done_o) begin
            if (dn_q.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               d = dn_q.pop_front();
               check("latency", 64'(cyc - hs_cyc + 2), 64'(d.lat));
               if (d.chk_data) check("done_data", bus.data_o, d.data);
               check("err", {63'd0, bus.err_o}, {63'd0, d.err});
               if (!d.is_flush) check("hold_enables", {56'd0, bus.save_en_o, bus.flush_o}, 64'd0);
               $display("done: flush=%0d lat=%0d data=%h err=%0d", d.is_flush, cyc - hs_cyc + 2, bus.data_o, bus.err_o);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(bit fl, logic [1:0] ocu);
      int g = 0;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_flush_i = fl;
      bus.cmd_ocu_i   = ocu;
      while (!bus.cmd_ready_o && g < 50) begin
         tick();
         g++;
      end
      if (g >= 50) check("cmd_timeout", 64'd0, 64'd1);
      tick();
      hs_cyc = cyc;
      bus.cmd_valid_i = 1'b0;
   endtask

   task automatic wait_done();
      int g = 0;
      while (dn_q.size() != 0 && g < 40) begin
         if (bus.cmd_ready_o) leak++;
         tick();
         g++;
      end
      check("done_timeout", 64'(dn_q.size()), 64'd0);
      check("enable_seen", 64'(ev_q.size()), 64'd0);
      check("cmd_ready_while_busy", 64'(leak), 64'd0);
      leak = 0;
   endtask

   // Load a kernel: beat i carries kern bits [63-16i -: 16]. gap2 idles before
   // beat 2; rnd adds 0..2 idle cycles before every beat.
   task automatic do_load(logic [1:0] ocu, logic [63:0] kern, bit rnd, int gap2,
                          int bad_beat, bit hold_pend);
      int   gaps = 0;
      int   gap;
      int   g;
      bit   eff_bad = 1'b0;
      dn_t  d;
      ev_t  e;
`ifdef WEIGHT_LOADER_PARITY_EN
      eff_bad = (bad_beat >= 0);
`endif
      model_err = model_err | eff_bad;
      if (!eff_bad) begin
         e.is_flush = 1'b0;
         e.oh       = 4'b0001 << ocu;
         e.data     = kern;
         ev_q.push_back(e);
      end
      send_cmd(1'b0, ocu);
      check("busy_in_fill", {63'd0, bus.busy_o}, 64'd1);
      if (hold_pend) begin
         bus.cmd_valid_i = 1'b1;
         bus.cmd_flush_i = 1'b0;
         bus.cmd_ocu_i   = 2'd3;
      end
      for (int i = 0; i < BEATS; i++) begin
         gap = (i == 2) ? gap2 : 0;
         if (rnd) gap += $urandom_range(0, 2);
         bus.beat_valid_i = 1'b0;
         repeat (gap) begin
            if (bus.cmd_ready_o) leak++;
            tick();
         end
         gaps += gap;
         bus.beat_i       = kern[63-16*i -: 16];
         bus.beat_par_i   = (^kern[63-16*i -: 16]) ^ (i == bad_beat);
         bus.beat_valid_i = 1'b1;
         g = 0;
         while (!bus.beat_ready_o && g < 20) begin
            tick();
            g++;
         end
         if (g >= 20) check("beat_timeout", 64'd0, 64'd1);
         if (bus.cmd_ready_o) leak++;
         tick();
      end
      bus.beat_valid_i = 1'b0;
      d.is_flush = 1'b0;
      d.chk_data = !eff_bad;
      d.data     = kern;
      d.lat      = 1 + BEATS + 2 + gaps;
      d.err      = model_err;
      dn_q.push_back(d);
      wait_done();
      model_data = kern;
      if (hold_pend) check("ready_after_hold", {63'd0, bus.cmd_ready_o}, 64'd1);
   endtask

   task automatic do_flush(logic [1:0] ocu);
      ev_t e;
      dn_t d;
      e.is_flush = 1'b1;
      e.oh       = 4'b0001 << ocu;
      e.data     = model_data;
      ev_q.push_back(e);
      d.is_flush = 1'b1;
      d.chk_data = 1'b1;
      d.data     = model_data;
      d.lat      = 2;
      d.err      = model_err;
      dn_q.push_back(d);
      send_cmd(1'b1, ocu);
      wait_done();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] k;
      bus.cmd_valid_i  = 1'b0;
      bus.cmd_flush_i  = 1'b0;
      bus.cmd_ocu_i    = '0;
      bus.beat_valid_i = 1'b0;
      bus.beat_i       = '0;
      bus.beat_par_i   = 1'b0;
      repeat (3) tick();
      // Reset state, still inside reset
      check("rst_data",       bus.data_o, 64'd0);
      check("rst_save",       {60'd0, bus.save_en_o}, 64'd0);
      check("rst_flush",      {60'd0, bus.flush_o}, 64'd0);
      check("rst_done",       {63'd0, bus.done_o}, 64'd0);
      check("rst_err",        {63'd0, bus.err_o}, 64'd0);
      check("rst_busy",       {63'd0, bus.busy_o}, 64'd0);
      check("rst_cmd_ready",  {63'd0, bus.cmd_ready_o}, 64'd1);
      check("rst_beat_ready", {63'd0, bus.beat_ready_o}, 64'd0);
      rst = 1'b0;
      tick();

      // Directed load, back-to-back beats
      do_load(2'd2, 64'hAAAA_5555_0F0F_F0F0, 1'b0, 0, -1, 1'b0);
      // Same load with a 3-cycle stall between beats 1 and 2
      do_load(2'd2, 64'hAAAA_5555_0F0F_F0F0, 1'b0, 3, -1, 1'b0);
      // Flush, data must be unchanged
      do_flush(2'd1);

      // Beats offered in IDLE are refused and do not disturb data_o
      bus.beat_valid_i = 1'b1;
      bus.beat_i       = 16'hDEAD;
      for (int i = 0; i < 3; i++) begin
         check("beat_ready_idle", {63'd0, bus.beat_ready_o}, 64'd0);
         tick();
      end
      bus.beat_valid_i = 1'b0;
      do_flush(2'd0);

      // Reset after beat 2 aborts the load
      send_cmd(1'b0, 2'd0);
      for (int i = 0; i < 3; i++) begin
         bus.beat_i       = 16'h1234 + 16'(i);
         bus.beat_par_i   = ^bus.beat_i;
         bus.beat_valid_i = 1'b1;
         tick();
      end
      bus.beat_valid_i = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_data = '0;
      model_err  = 1'b0;
      check("abort_busy",  {63'd0, bus.busy_o}, 64'd0);
      check("abort_data",  bus.data_o, 64'd0);
      check("abort_ready", {63'd0, bus.cmd_ready_o}, 64'd1);
      repeat (4) tick();
      check("abort_no_enable", 64'(ev_q.size()), 64'd0);
      do_load(2'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, -1, 1'b0);

      // Command for OCU 3 held pending while busy; accepted right after HOLD
      do_load(2'd1, 64'hCAFE_F00D_1357_2468, 1'b0, 0, -1, 1'b1);
      do_load(2'd3, 64'h8000_0001_7FFF_FFFE, 1'b0, 0, -1, 1'b0);

      // Randomized mix against the reference model
      for (int n = 0; n < 14; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            do_flush(2'($urandom_range(0, 3)));
         end else begin
            k = {$urandom, $urandom};
            do_load(2'($urandom_range(0, 3)), k, 1'b1, 0, -1, 1'b0);
         end
         repeat ($urandom_range(0, 2)) tick();
      end

`ifdef WEIGHT_LOADER_PARITY_EN
      // Bad parity on beat 1: no save, done still pulses, err sticky
      do_load(2'd2, 64'h1111_2222_3333_4444, 1'b0, 0, 1, 1'b0);
      do_load(2'd1, 64'h5555_6666_7777_8888, 1'b0, 0, -1, 1'b0);
      do_flush(2'd3);
`endif

      repeat (3) tick();
      check("ev_q_empty", 64'(ev_q.size()), 64'd0);
      check("dn_q_empty", 64'(dn_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
